mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Pipeline stage directly downstream of the decode/execute datapath.
- Captures the execute-stage result and control bits into an EX/MEM register, performs the data-memory access and resolves branches.
- Captures the result into a MEM/WB register and drives the write-back port of the register bank (write register, enable, data).
- Also exports EX/MEM and MEM/WB destination information for a later forwarding unit.

Parameters:
- ADDR_W, 8: word-address width of the internal data memory (2^ADDR_W 32-bit words).
- DATA_W, 32: datapath width.

Ports:
- clock  in  1  rising-edge clock.
- resetGral  in  1  asynchronous reset, active-low.
- aluResult  in  DATA_W  ALU output / memory byte address from execute.
- aluZero  in  1  ALU zero flag.
- storeData  in  DATA_W  second register operand; the store data.
- branchTarget  in  DATA_W  computed branch target PC.
- writeReg  in  5  destination register.
- RegWrite, MemRead, MemWrite, MemtoReg, Branch  in  1 each  control bits from execute.
- stall  in  1  hold both pipeline registers.
- flush  in  1  load a bubble into EX/MEM.
- pcSrc  out  1  branch taken.
- pcBranchTarget  out  DATA_W  target to fetch when pcSrc=1.
- exmemWriteReg  out  5  EX/MEM destination (forwarding).
- exmemRegWrite  out  1  EX/MEM write enable (forwarding).
- exmemAluResult  out  DATA_W  EX/MEM ALU result (forwarding).
- wbWriteReg  out  5  to register bank writeReg.
- wbRegWrite  out  1  to register bank regWrite.
- wbWriteData  out  DATA_W  to register bank writeData.
- memFault  out  1  misaligned access flag, aligned with write-back.

Behaviour:
- Reset (resetGral=0, asynchronous): all EX/MEM and MEM/WB fields, and therefore all outputs, are 0. Memory contents are not reset and are retained across reset. Release is synchronous to the next clock edge.
- EX/MEM capture at each rising edge with stall=0:
  - flush=1: all control bits (RegWrite, MemRead, MemWrite, MemtoReg, Branch) are 0; data fields are don't-care, driven 0.
  - otherwise: all inputs are captured.
- stall=1: EX/MEM and MEM/WB hold their values and the memory write is suppressed. stall overrides flush; the hazard unit holds flush until stall drops.
- Address: word index = exmem aluResult[ADDR_W+1:2]. Upper bits are ignored, so addresses wrap modulo 2^ADDR_W words.
- Aligned means aluResult[1:0]==0.
- Store: mem[index] <= storeData at the edge on which the store leaves EX/MEM (stall=0, MemWrite=1, aligned). Exactly one write per store, regardless of stall length.
- Load: synchronous read. The word is captured into MEM/WB read data at the same edge. If misaligned, the read data is forced to 0.
- memFault: registered into MEM/WB as (MemRead|MemWrite) & misaligned. A misaligned store writes nothing.
- MEM/WB capture (stall=0): RegWrite, writeReg, MemtoReg, aluResult, read data, fault.
- wbWriteData = MemtoReg ? read data : aluResult (mux on MEM/WB contents).
- wbRegWrite is forced 0 when writeReg==0 (register 0 is never written).
- Latency: inputs sampled at edge N appear on the forwarding outputs after edge N and on the wb* outputs after edge N+1.
- Store followed immediately by a load to the same address: the store writes at edge N+1; the load reads at edge N+2 and returns the new data. No bypass is needed.
- Branch: pcSrc = exmem Branch & exmem aluZero, combinational from EX/MEM. pcBranchTarget = exmem branchTarget. pcSrc is valid for one cycle (longer if stalled).
- Reset asserted mid-operation: in-flight stores not yet committed at the edge are lost; no partial write occurs.

Test Plan:
- Reset, then aluResult=0x14, RegWrite=1, writeReg=5, MemtoReg=0 at edge 1 -> after edge 2: wbRegWrite=1, wbWriteReg=5, wbWriteData=0x14, memFault=0.
- Store 0xDEADBEEF to address 0x20, next cycle load from 0x20 with MemtoReg=1, writeReg=8 -> load's wbWriteData=0xDEADBEEF two edges after its capture.
- Store with address 0x22 (misaligned), then load from 0x20 -> memFault=1 on the store's write-back cycle; the load returns the previous contents, unchanged.
- Branch=1 with aluZero=1 and branchTarget=0x40 -> pcSrc=1, pcBranchTarget=0x40 for one cycle. Same stimulus with aluZero=0 -> pcSrc=0.
- Store held under stall=1 for 3 cycles, with the store data changed in memory by a second store to the same address afterwards -> exactly one write per store; wb outputs frozen during the stall. flush=1 with stall=0 -> EX/MEM bubble, and wbRegWrite=0 one edge later.
- Assert resetGral=0 mid-sequence between edges -> all outputs 0 immediately (asynchronously). Previously stored words are still readable after release. RegWrite=1 with writeReg=0 -> wbRegWrite=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//   Memory / write-back portion of the pipeline. Registers the execute-stage
//   result into EX/MEM, performs the data-memory access, resolves branches,
//   then registers the result into MEM/WB and drives the register-bank write
//   port. EX/MEM and MEM/WB destination information is also exported for a
//   forwarding unit.
//
// Ports
//   clock, resetGral        rising-edge clock, async active-low reset
//   aluResult, aluZero      ALU result (also memory byte address) and zero flag
//   storeData               store data
//   branchTarget            computed branch target PC
//   writeReg                destination register
//   RegWrite..Branch        control bits from execute
//   stall, flush            hold both registers / bubble into EX/MEM
//   pcSrc, pcBranchTarget   branch taken and its target (from EX/MEM)
//   exmem*                  EX/MEM destination info for forwarding
//   wb*                     register-bank write port (from MEM/WB)
//   memFault                misaligned memory access, aligned with write-back
// -----------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              resetGral,
  input  logic [DATA_W-1:0] aluResult,
  input  logic              aluZero,
  input  logic [DATA_W-1:0] storeData,
  input  logic [DATA_W-1:0] branchTarget,
  input  logic [4:0]        writeReg,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic              Branch,
  input  logic              stall,
  input  logic              flush,
  output logic              pcSrc,
  output logic [DATA_W-1:0] pcBranchTarget,
  output logic [4:0]        exmemWriteReg,
  output logic              exmemRegWrite,
  output logic [DATA_W-1:0] exmemAluResult,
  output logic [4:0]        wbWriteReg,
  output logic              wbRegWrite,
  output logic [DATA_W-1:0] wbWriteData,
  output logic              memFault
);

  // EX/MEM register fields
  logic [DATA_W-1:0] em_alu_q, em_alu_d;
  logic              em_zero_q, em_zero_d;
  logic [DATA_W-1:0] em_store_q, em_store_d;
  logic [DATA_W-1:0] em_target_q, em_target_d;
  logic [4:0]        em_wreg_q, em_wreg_d;
  logic              em_regwrite_q, em_regwrite_d;
  logic              em_memread_q, em_memread_d;
  logic              em_memwrite_q, em_memwrite_d;
  logic              em_memtoreg_q, em_memtoreg_d;
  logic              em_branch_q, em_branch_d;

  // MEM/WB register fields
  logic [DATA_W-1:0] mw_alu_q, mw_alu_d;
  logic [DATA_W-1:0] mw_rdata_q, mw_rdata_d;
  logic [4:0]        mw_wreg_q, mw_wreg_d;
  logic              mw_regwrite_q, mw_regwrite_d;
  logic              mw_memtoreg_q, mw_memtoreg_d;
  logic              mw_fault_q, mw_fault_d;

  // Data memory: not reset, contents survive resetGral.
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  logic [ADDR_W-1:0] word_idx_s;
  logic              aligned_s;

  // Upper address bits are ignored, so addresses wrap within the memory.
  assign word_idx_s = em_alu_q[ADDR_W+1:2];
  assign aligned_s  = (em_alu_q[1:0] == 2'b00);

  // EX/MEM next state: hold on stall, bubble on flush, else capture.
  always_comb begin
    em_alu_d      = em_alu_q;
    em_zero_d     = em_zero_q;
    em_store_d    = em_store_q;
    em_target_d   = em_target_q;
    em_wreg_d     = em_wreg_q;
    em_regwrite_d = em_regwrite_q;
    em_memread_d  = em_memread_q;
    em_memwrite_d = em_memwrite_q;
    em_memtoreg_d = em_memtoreg_q;
    em_branch_d   = em_branch_q;
    if (stall) begin
      // stall dominates flush; everything keeps its value
    end else if (flush) begin
      em_alu_d      = {DATA_W{1'b0}};
      em_zero_d     = 1'b0;
      em_store_d    = {DATA_W{1'b0}};
      em_target_d   = {DATA_W{1'b0}};
      em_wreg_d     = 5'd0;
      em_regwrite_d = 1'b0;
      em_memread_d  = 1'b0;
      em_memwrite_d = 1'b0;
      em_memtoreg_d = 1'b0;
      em_branch_d   = 1'b0;
    end else begin
      em_alu_d      = aluResult;
      em_zero_d     = aluZero;
      em_store_d    = storeData;
      em_target_d   = branchTarget;
      em_wreg_d     = writeReg;
      em_regwrite_d = RegWrite;
      em_memread_d  = MemRead;
      em_memwrite_d = MemWrite;
      em_memtoreg_d = MemtoReg;
      em_branch_d   = Branch;
    end
  end

  // MEM/WB next state: hold on stall, else capture the memory-stage result.
  always_comb begin
    mw_alu_d      = mw_alu_q;
    mw_rdata_d    = mw_rdata_q;
    mw_wreg_d     = mw_wreg_q;
    mw_regwrite_d = mw_regwrite_q;
    mw_memtoreg_d = mw_memtoreg_q;
    mw_fault_d    = mw_fault_q;
    if (!stall) begin
      mw_alu_d      = em_alu_q;
      mw_rdata_d    = aligned_s ? mem_q[word_idx_s] : {DATA_W{1'b0}};
      mw_wreg_d     = em_wreg_q;
      mw_regwrite_d = em_regwrite_q;
      mw_memtoreg_d = em_memtoreg_q;
      mw_fault_d    = (em_memread_q | em_memwrite_q) & ~aligned_s;
    end else begin
      mw_fault_d    = mw_fault_q;
    end
  end

  // Pipeline registers with asynchronous clear.
  always_ff @(posedge clock or negedge resetGral) begin
    if (!resetGral) begin
      em_alu_q      <= {DATA_W{1'b0}};
      em_zero_q     <= 1'b0;
      em_store_q    <= {DATA_W{1'b0}};
      em_target_q   <= {DATA_W{1'b0}};
      em_wreg_q     <= 5'd0;
      em_regwrite_q <= 1'b0;
      em_memread_q  <= 1'b0;
      em_memwrite_q <= 1'b0;
      em_memtoreg_q <= 1'b0;
      em_branch_q   <= 1'b0;
      mw_alu_q      <= {DATA_W{1'b0}};
      mw_rdata_q    <= {DATA_W{1'b0}};
      mw_wreg_q     <= 5'd0;
      mw_regwrite_q <= 1'b0;
      mw_memtoreg_q <= 1'b0;
      mw_fault_q    <= 1'b0;
    end else begin
      em_alu_q      <= em_alu_d;
      em_zero_q     <= em_zero_d;
      em_store_q    <= em_store_d;
      em_target_q   <= em_target_d;
      em_wreg_q     <= em_wreg_d;
      em_regwrite_q <= em_regwrite_d;
      em_memread_q  <= em_memread_d;
      em_memwrite_q <= em_memwrite_d;
      em_memtoreg_q <= em_memtoreg_d;
      em_branch_q   <= em_branch_d;
      mw_alu_q      <= mw_alu_d;
      mw_rdata_q    <= mw_rdata_d;
      mw_wreg_q     <= mw_wreg_d;
      mw_regwrite_q <= mw_regwrite_d;
      mw_memtoreg_q <= mw_memtoreg_d;
      mw_fault_q    <= mw_fault_d;
    end
  end

  // Memory write: only on the edge the store leaves EX/MEM, so a stalled
  // store commits exactly once; resetGral gating drops an in-flight store.
  always_ff @(posedge clock) begin
    if (resetGral && !stall && em_memwrite_q && aligned_s) begin
      mem_q[word_idx_s] <= em_store_q;
    end
  end

  assign pcSrc          = em_branch_q & em_zero_q;
  assign pcBranchTarget = em_target_q;
  assign exmemWriteReg  = em_wreg_q;
  assign exmemRegWrite  = em_regwrite_q;
  assign exmemAluResult = em_alu_q;

  // Register 0 is hard-wired, so never request a write to it.
  assign wbRegWrite  = mw_regwrite_q & (mw_wreg_q != 5'd0);
  assign wbWriteReg  = mw_wreg_q;
  assign wbWriteData = mw_memtoreg_q ? mw_rdata_q : mw_alu_q;
  assign memFault    = mw_fault_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clock = 1'b0;
  logic        resetGral;
  logic [31:0] aluResult, storeData, branchTarget;
  logic        aluZero;
  logic [4:0]  writeReg;
  logic        RegWrite, MemRead, MemWrite, MemtoReg, Branch;
  logic        stall, flush;
  logic        pcSrc;
  logic [31:0] pcBranchTarget, exmemAluResult, wbWriteData;
  logic [4:0]  exmemWriteReg, wbWriteReg;
  logic        exmemRegWrite, wbRegWrite, memFault;

  int checks = 0;
  int failures = 0;

  mem_wb_stage #(.ADDR_W(8), .DATA_W(32)) dut (
    .clock(clock), .resetGral(resetGral),
    .aluResult(aluResult), .aluZero(aluZero), .storeData(storeData),
    .branchTarget(branchTarget), .writeReg(writeReg),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .Branch(Branch), .stall(stall), .flush(flush),
    .pcSrc(pcSrc), .pcBranchTarget(pcBranchTarget),
    .exmemWriteReg(exmemWriteReg), .exmemRegWrite(exmemRegWrite),
    .exmemAluResult(exmemAluResult), .wbWriteReg(wbWriteReg),
    .wbRegWrite(wbRegWrite), .wbWriteData(wbWriteData), .memFault(memFault)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and move away from it before sampling/driving.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] alu, input logic zero, input logic [31:0] sd,
                       input logic [31:0] bt, input logic [4:0] wr, input logic rw,
                       input logic mr, input logic mw, input logic m2r, input logic br);
    aluResult = alu; aluZero = zero; storeData = sd; branchTarget = bt;
    writeReg = wr; RegWrite = rw; MemRead = mr; MemWrite = mw;
    MemtoReg = m2r; Branch = br;
  endtask

  task automatic idle();
    drive(32'h0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    resetGral = 1'b0; stall = 1'b0; flush = 1'b0;
    idle();
    #12;
    check_eq("rst_wbData", wbWriteData, 32'h0);
    check_eq("rst_wbRegWrite", {31'd0, wbRegWrite}, 32'h0);
    check_eq("rst_pcSrc", {31'd0, pcSrc}, 32'h0);
    check_eq("rst_exmemWreg", {27'd0, exmemWriteReg}, 32'h0);
    resetGral = 1'b1;

    // ALU result write-back
    drive(32'h14, 1'b0, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("fwd_wreg", {27'd0, exmemWriteReg}, 32'd5);
    check_eq("fwd_rw", {31'd0, exmemRegWrite}, 32'd1);
    check_eq("fwd_alu", exmemAluResult, 32'h14);
    idle();
    tick();
    check_eq("alu_wbRegWrite", {31'd0, wbRegWrite}, 32'd1);
    check_eq("alu_wbWreg", {27'd0, wbWriteReg}, 32'd5);
    check_eq("alu_wbData", wbWriteData, 32'h14);
    check_eq("alu_fault", {31'd0, memFault}, 32'd0);

    // Store then back-to-back load of the same word
    drive(32'h20, 1'b0, 32'hDEADBEEF, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h20, 1'b0, 32'h0, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    check_eq("ld_wbData", wbWriteData, 32'hDEADBEEF);
    check_eq("ld_wbWreg", {27'd0, wbWriteReg}, 32'd8);

    // Misaligned store writes nothing and flags a fault
    drive(32'h22, 1'b0, 32'h12345678, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h20, 1'b0, 32'h0, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check_eq("mis_fault", {31'd0, memFault}, 32'd1);
    idle();
    tick();
    check_eq("mis_ldData", wbWriteData, 32'hDEADBEEF);
    check_eq("mis_ldFault", {31'd0, memFault}, 32'd0);

    // Branch taken / not taken
    drive(32'h0, 1'b1, 32'h0, 32'h40, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_eq("br_pcSrc", {31'd0, pcSrc}, 32'd1);
    check_eq("br_target", pcBranchTarget, 32'h40);
    idle();
    tick();
    check_eq("br_oneCycle", {31'd0, pcSrc}, 32'd0);
    drive(32'h0, 1'b0, 32'h0, 32'h40, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_eq("brnt_pcSrc", {31'd0, pcSrc}, 32'd0);

    // Stall: store held three cycles, wb frozen, then one commit per store
    drive(32'h77, 1'b0, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(32'h30, 1'b0, 32'hAAAA0001, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(32'h30, 1'b0, 32'h0, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("stall_wbData%0d", i), wbWriteData, 32'h77);
      check_eq($sformatf("stall_wbWreg%0d", i), {27'd0, wbWriteReg}, 32'd3);
      check_eq($sformatf("stall_exmem%0d", i), exmemAluResult, 32'h30);
    end
    stall = 1'b0;
    tick();
    drive(32'h30, 1'b0, 32'hBBBB0002, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("stall_ldA", wbWriteData, 32'hAAAA0001);
    check_eq("stall_ldWreg", {27'd0, wbWriteReg}, 32'd10);
    drive(32'h30, 1'b0, 32'h0, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    check_eq("stall_ldB", wbWriteData, 32'hBBBB0002);

    // Flush inserts a bubble
    drive(32'h55, 1'b0, 32'h0, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    check_eq("fl_exmemRw", {31'd0, exmemRegWrite}, 32'd0);
    check_eq("fl_exmemAlu", exmemAluResult, 32'h0);
    flush = 1'b0;
    idle();
    tick();
    check_eq("fl_wbRegWrite", {31'd0, wbRegWrite}, 32'd0);

    // Async reset with a store in flight
    drive(32'h99, 1'b0, 32'h0, 32'h0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(32'h20, 1'b0, 32'hCCCC0003, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check_eq("pre_rst_wbData", wbWriteData, 32'h99);
    #2;
    resetGral = 1'b0;
    #1;
    check_eq("arst_wbData", wbWriteData, 32'h0);
    check_eq("arst_wbRw", {31'd0, wbRegWrite}, 32'd0);
    check_eq("arst_wbWreg", {27'd0, wbWriteReg}, 32'd0);
    check_eq("arst_exmemAlu", exmemAluResult, 32'h0);
    check_eq("arst_exmemRw", {31'd0, exmemRegWrite}, 32'd0);
    idle();
    tick();
    resetGral = 1'b1;
    drive(32'h20, 1'b0, 32'h0, 32'h0, 5'd14, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive(32'h30, 1'b0, 32'h0, 32'h0, 5'd15, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    check_eq("ret_ld20", wbWriteData, 32'hDEADBEEF);
    idle();
    tick();
    check_eq("ret_ld30", wbWriteData, 32'hBBBB0002);

    // Register 0 is never written
    drive(32'h5, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    check_eq("r0_wbRegWrite", {31'd0, wbRegWrite}, 32'd0);
    check_eq("r0_wbData", wbWriteData, 32'h5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
